div_issue_ctrl: RTL and testbench

//  EX-stage front end for the iterative divider. Accepts a DIV/DIVU from the issuing pipe,

---
 rtl/div_issue_ctrl_pkg.sv | 11 +
 rtl/div_issue_ctrl.sv | 73 +++++++
 tb/tb_div_issue_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg: shared state encoding, width and reset polarity for the divider issue controller
package div_issue_ctrl_pkg;
  localparam int DIV_DATA_W = 32;
  localparam logic RST_ENABLE = 1'b0;
  typedef enum logic [3:0] {
    DIV_STATE_IDLE  = 4'b0001,
    DIV_STATE_BUSY  = 4'b0010,
    DIV_STATE_DONE  = 4'b0100,
    DIV_STATE_DRAIN = 4'b1000
  } div_state_e;
endpackage

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage divider front end; define DIV_ZERO_FAST_EN to resolve zero divisors without the divider
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_div_req,
  input  logic              ex_div_signed,
  input  logic [DATA_W-1:0] ex_dividend,
  input  logic [DATA_W-1:0] ex_divisor,
  input  logic              flush,
  output logic              div_stall,
  output logic              div_start,
  output logic              div_signed,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic              div_end,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [DATA_W-1:0] div_remainder,
  output logic              hilo_we,
  output logic [DATA_W-1:0] hi_wdata,
  output logic [DATA_W-1:0] lo_wdata
);
  div_state_e state;
  logic       zero_fast;
  logic       accept;
`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = ex_divisor == '0;
`else
  assign zero_fast = 1'b0;
`endif
  assign accept = (state == DIV_STATE_IDLE) && ex_div_req && !flush;
  // the divider re-arms only on start & !end, so start must fall in the end cycle itself
  assign div_start = (state == DIV_STATE_BUSY) && !div_end;
  assign hilo_we   = (state == DIV_STATE_DONE) && !flush;
  assign div_stall = resetn && ((state == DIV_STATE_BUSY) || accept ||
                                ((state == DIV_STATE_DRAIN) && ex_div_req));
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      state        <= DIV_STATE_IDLE;
      div_signed   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      hi_wdata     <= '0;
      lo_wdata     <= '0;
    end else begin
      case (state)
        DIV_STATE_IDLE: if (accept) begin
          div_signed   <= ex_div_signed;
          div_dividend <= ex_dividend;
          div_divisor  <= ex_divisor;
          state        <= zero_fast ? DIV_STATE_DONE : DIV_STATE_BUSY;
          if (zero_fast) begin
            lo_wdata <= '1;
            hi_wdata <= ex_dividend;
          end
        end
        DIV_STATE_BUSY: if (flush) begin
          state <= div_end ? DIV_STATE_IDLE : DIV_STATE_DRAIN;
        end else if (div_end) begin
          state    <= DIV_STATE_DONE;
          lo_wdata <= div_quotient;
          hi_wdata <= div_remainder;
        end
        DIV_STATE_DONE: state <= DIV_STATE_IDLE;
        DIV_STATE_DRAIN: if (div_end) state <= DIV_STATE_IDLE;
        default: state <= DIV_STATE_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed tests of the divider issue controller against a behavioural iterative divider
module tb_div_issue_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_div_req, ex_div_signed, flush;
  logic [31:0] ex_dividend, ex_divisor;
  logic        div_stall, div_start, div_signed, div_end, hilo_we;
  logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder, hi_wdata, lo_wdata;
  int checks = 0;
  int errors = 0;

  div_issue_ctrl dut (
    .clk(clk), .resetn(resetn), .ex_div_req(ex_div_req), .ex_div_signed(ex_div_signed),
    .ex_dividend(ex_dividend), .ex_divisor(ex_divisor), .flush(flush), .div_stall(div_stall),
    .div_start(div_start), .div_signed(div_signed), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_end(div_end), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mag(input logic s, input logic [31:0] v);
    return (s && v[31]) ? -v : v;
  endfunction

  // behavioural divider: 2 busy cycles when |dividend|<|divisor|, else 33, result with a one-cycle end pulse
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_q, m_r;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0; m_cnt <= 0; div_end <= 1'b0; div_quotient <= '0; div_remainder <= '0;
      m_q <= '0; m_r <= '0;
    end else begin
      div_end <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 0) begin
          div_end <= 1'b1; m_busy <= 1'b0; div_quotient <= m_q; div_remainder <= m_r;
        end else m_cnt <= m_cnt - 1;
      end else if (div_start) begin
        m_busy <= 1'b1;
        m_cnt  <= (mag(div_signed, div_dividend) < mag(div_signed, div_divisor)) ? 0 : 31;
        m_q    <= div_signed ? 32'($signed(div_dividend) / $signed(div_divisor)) : div_dividend / div_divisor;
        m_r    <= div_signed ? 32'($signed(div_dividend) % $signed(div_divisor)) : div_dividend % div_divisor;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int starts, output logic [31:0] lo, output logic [31:0] hi,
                         output logic stall0, output logic stall_at, output logic stall_after,
                         output logic start_after, output bit ops_ok);
    bit got = 0;
    tick;
    ex_div_req = 1'b1; ex_div_signed = s; ex_dividend = a; ex_divisor = b;
    #1 stall0 = div_stall;
    lat = 0; starts = 0; ops_ok = 1; lo = 'x; hi = 'x; stall_at = 1'bx;
    while (!got && lat < 100) begin
      tick;
      lat++;
      ex_dividend = ~a; ex_divisor = ~b;
      if (div_start) starts++;
      if (hilo_we) begin
        got = 1; lo = lo_wdata; hi = hi_wdata; stall_at = div_stall;
      end else if (div_stall && (div_dividend !== a || div_divisor !== b || div_signed !== s)) ops_ok = 0;
    end
    tick;
    ex_div_req = 1'b0;
    #1 stall_after = div_stall;
    start_after = div_start | hilo_we;
  endtask

  task automatic test_reset;
    ex_div_req = 1'b1;
    #1;
    checks++; if (div_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", div_stall); end
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b exp 0", div_start); end
    checks++; if (hilo_we !== 1'b0) begin errors++; $display("FAIL reset_hilo_we: got %b exp 0", hilo_we); end
    checks++; if ({div_signed, div_dividend, div_divisor} !== 65'd0) begin errors++; $display("FAIL reset_operands: got %b %h %h exp 0 0 0", div_signed, div_dividend, div_divisor); end
    checks++; if ({hi_wdata, lo_wdata} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h %h exp 0 0", hi_wdata, lo_wdata); end
    ex_div_req = 1'b0;
  endtask

  task automatic test_divu;
    int lat, starts; logic [31:0] lo, hi; logic s0, sa, saf, st; bit ok;
    run_div(1'b0, 32'd100, 32'd7, lat, starts, lo, hi, s0, sa, saf, st, ok);
    checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL divu_req_stall: got %b exp 1", s0); end
    checks++; if (lat !== 35) begin errors++; $display("FAIL divu_latency: got %0d exp 35", lat); end
    checks++; if (starts !== 33) begin errors++; $display("FAIL divu_start_cycles: got %0d exp 33", starts); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu_result: got lo=%h hi=%h exp lo=0000000e hi=00000002", lo, hi); end
    checks++; if (sa !== 1'b0) begin errors++; $display("FAIL divu_stall_done: got %b exp 0", sa); end
    checks++; if (saf !== 1'b0 || st !== 1'b0) begin errors++; $display("FAIL divu_after: got stall=%b start|we=%b exp 0 0", saf, st); end
    checks++; if (!ok) begin errors++; $display("FAIL divu_operands_held: got unstable exp stable"); end
  endtask

  task automatic test_div_signed;
    int lat, starts; logic [31:0] lo, hi; logic s0, sa, saf, st; bit ok;
    run_div(1'b1, -32'sd100, 32'd7, lat, starts, lo, hi, s0, sa, saf, st, ok);
    checks++; if (lo !== 32'hFFFF_FFF2 || hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL div_result: got lo=%h hi=%h exp lo=fffffff2 hi=fffffffe", lo, hi); end
    checks++; if (!ok) begin errors++; $display("FAIL div_operands_held: got unstable exp stable"); end
    checks++; if (lat !== 35) begin errors++; $display("FAIL div_latency: got %0d exp 35", lat); end
  endtask

  task automatic test_small;
    int lat, starts; logic [31:0] lo, hi; logic s0, sa, saf, st; bit ok;
    run_div(1'b0, 32'd3, 32'd10, lat, starts, lo, hi, s0, sa, saf, st, ok);
    checks++; if (lo !== 32'd0 || hi !== 32'd3) begin errors++; $display("FAIL small_result: got lo=%h hi=%h exp lo=0 hi=3", lo, hi); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL small_latency: got %0d exp 4", lat); end
    checks++; if (starts !== 2) begin errors++; $display("FAIL small_start_cycles: got %0d exp 2", starts); end
  endtask

  task automatic test_flush_drain;
    int n = 0; int end_n = -1; bit bad = 0; bit got = 0; logic [31:0] lo, hi;
    tick;
    ex_div_req = 1'b1; ex_div_signed = 1'b0; ex_dividend = 32'hFFFF_FFFF; ex_divisor = 32'd3;
    repeat (5) tick;
    ex_div_req = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0;
    ex_div_req = 1'b1; ex_dividend = 32'd100; ex_divisor = 32'd7;
    #1;
    checks++; if (div_stall !== 1'b1 || div_start !== 1'b0 || hilo_we !== 1'b0) begin errors++; $display("FAIL drain_entry: got stall=%b start=%b we=%b exp 1 0 0", div_stall, div_start, hilo_we); end
    while (!got && n < 100) begin
      tick;
      n++;
      if (div_end && end_n < 0) end_n = n;
      if (hilo_we) begin got = 1; lo = lo_wdata; hi = hi_wdata; end
      else if (n <= 28 && (div_start || !div_stall)) bad = 1;
    end
    tick;
    ex_div_req = 1'b0;
    checks++; if (bad) begin errors++; $display("FAIL drain_hold: got start or unstall in drain exp stalled idle divider"); end
    checks++; if (end_n !== 28) begin errors++; $display("FAIL drain_end_cycle: got %0d exp 28", end_n); end
    checks++; if (n !== 64) begin errors++; $display("FAIL drain_then_accept_latency: got %0d exp 64", n); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL drain_next_result: got lo=%h hi=%h exp 0000000e 00000002", lo, hi); end
  endtask

  task automatic test_flush_end;
    int lat, starts; logic [31:0] lo, hi; logic s0, sa, saf, st; bit ok;
    tick;
    ex_div_req = 1'b1; ex_div_signed = 1'b0; ex_dividend = 32'd3; ex_divisor = 32'd10;
    repeat (2) tick;
    tick;
    ex_div_req = 1'b0; flush = 1'b1;
    #1;
    checks++; if (div_start !== 1'b0 || hilo_we !== 1'b0) begin errors++; $display("FAIL flush_end_cycle: got start=%b we=%b exp 0 0", div_start, hilo_we); end
    tick;
    flush = 1'b0;
    checks++; if (hilo_we !== 1'b0 || div_stall !== 1'b0 || div_start !== 1'b0) begin errors++; $display("FAIL flush_end_next: got we=%b stall=%b start=%b exp 0 0 0", hilo_we, div_stall, div_start); end
    run_div(1'b0, 32'd100, 32'd7, lat, starts, lo, hi, s0, sa, saf, st, ok);
    checks++; if (lat !== 35 || lo !== 32'd14) begin errors++; $display("FAIL flush_end_recover: got lat=%0d lo=%h exp 35 0000000e", lat, lo); end
  endtask

  task automatic test_flush_done;
    int lat, starts; logic [31:0] lo, hi; logic s0, sa, saf, st; bit ok;
    tick;
    ex_div_req = 1'b1; ex_div_signed = 1'b0; ex_dividend = 32'd3; ex_divisor = 32'd10;
    repeat (3) tick;
    tick;
    ex_div_req = 1'b0; flush = 1'b1;
    #1;
    checks++; if (hilo_we !== 1'b0) begin errors++; $display("FAIL flush_done_we: got %b exp 0", hilo_we); end
    tick;
    flush = 1'b0;
    checks++; if (hilo_we !== 1'b0 || div_stall !== 1'b0) begin errors++; $display("FAIL flush_done_next: got we=%b stall=%b exp 0 0", hilo_we, div_stall); end
    run_div(1'b1, -32'sd100, 32'd7, lat, starts, lo, hi, s0, sa, saf, st, ok);
    checks++; if (lat !== 35 || hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL flush_done_recover: got lat=%0d hi=%h exp 35 fffffffe", lat, hi); end
  endtask

  task automatic test_async_reset;
    int lat, starts; logic [31:0] lo, hi; logic s0, sa, saf, st; bit ok;
    tick;
    ex_div_req = 1'b1; ex_div_signed = 1'b1; ex_dividend = 32'd100; ex_divisor = 32'd7;
    repeat (5) tick;
    #2 resetn = 1'b0;
    ex_div_req = 1'b0;
    #1;
    checks++; if ({div_stall, div_start, hilo_we, div_signed} !== 4'b0) begin errors++; $display("FAIL areset_ctrl: got %b exp 0000", {div_stall, div_start, hilo_we, div_signed}); end
    checks++; if ({div_dividend, div_divisor, hi_wdata, lo_wdata} !== 128'd0) begin errors++; $display("FAIL areset_data: got %h %h %h %h exp 0", div_dividend, div_divisor, hi_wdata, lo_wdata); end
    tick;
    resetn = 1'b1;
    run_div(1'b0, 32'd100, 32'd7, lat, starts, lo, hi, s0, sa, saf, st, ok);
    checks++; if (lat !== 35 || lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL areset_recover: got lat=%0d lo=%h hi=%h exp 35 0000000e 00000002", lat, lo, hi); end
  endtask

`ifdef DIV_ZERO_FAST_EN
  task automatic test_zero_fast;
    int lat, starts; logic [31:0] lo, hi; logic s0, sa, saf, st; bit ok;
    run_div(1'b0, 32'd9, 32'd0, lat, starts, lo, hi, s0, sa, saf, st, ok);
    checks++; if (lat !== 1 || starts !== 0) begin errors++; $display("FAIL zero_fast_timing: got lat=%0d starts=%0d exp 1 0", lat, starts); end
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd9) begin errors++; $display("FAIL zero_fast_result: got lo=%h hi=%h exp ffffffff 00000009", lo, hi); end
  endtask
`endif

  initial begin
    resetn = 1'b0; ex_div_req = 1'b0; ex_div_signed = 1'b0; flush = 1'b0;
    ex_dividend = '0; ex_divisor = '0;
    test_reset;
    @(negedge clk);
    resetn = 1'b1;
    test_divu;
    test_div_signed;
    test_small;
    test_flush_drain;
    test_flush_end;
    test_flush_done;
    test_async_reset;
`ifdef DIV_ZERO_FAST_EN
    test_zero_fast;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
